// File: rtl/rf_access_ctrl.sv
// Request/response front end for a 32x DW register file: sequences read pairs and single writes.
// Optional write-to-read bypass shadow enabled by defining RF_ACCESS_BYPASS_EN.
module rf_access_ctrl #(
  parameter int READ_WAIT = 1,
  parameter int DW        = 64
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [4:0]    req_a,
  input  logic [4:0]    req_b,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_a,
  output logic [DW-1:0] rsp_b,
  output logic          rsp_err,
  output logic [4:0]    RA,
  output logic [4:0]    RB,
  output logic [4:0]    RW,
  output logic          RegWr,
  output logic [DW-1:0] BusW,
  input  logic [DW-1:0] BusA,
  input  logic [DW-1:0] BusB
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_HOLD, RSP} state_t;

  state_t        state;
  state_t        nextState;
  logic [2:0]    cnt;
  logic          accept;
  logic [DW-1:0] rdA;
  logic [DW-1:0] rdB;

  assign req_ready = Rst_n && (state == IDLE);
  assign rsp_valid = (state == RSP);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!req_wr)               nextState = RD_WAIT;
          else if (req_a == 5'd31)   nextState = RSP;
          else                       nextState = WR_HOLD;
        end
      end
      RD_WAIT: if (cnt == 3'd1) nextState = RSP;
      WR_HOLD: nextState = RSP;
      RSP:     if (rsp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Addresses and write data only move on acceptance, so they never glitch while RegWr is high
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      RA      <= '0;
      RB      <= '0;
      RW      <= '0;
      BusW    <= '0;
      RegWr   <= 1'b0;
      cnt     <= '0;
      rsp_a   <= '0;
      rsp_b   <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (!req_wr) begin
              RA      <= req_a;
              RB      <= req_b;
              cnt     <= 3'(READ_WAIT);
              rsp_err <= 1'b0;
            end else begin
              rsp_a   <= '0;
              rsp_b   <= '0;
              rsp_err <= (req_a == 5'd31);
              if (req_a != 5'd31) begin
                RW    <= req_a;
                BusW  <= req_wdata;
                RegWr <= 1'b1;
              end
            end
          end
        end
        RD_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            rsp_a <= rdA;
            rsp_b <= rdB;
          end
        end
        WR_HOLD: RegWr <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef RF_ACCESS_BYPASS_EN
  logic [4:0]    shAddr;
  logic [DW-1:0] shData;
  logic          shValid;

  // WR_HOLD is never entered for register 31, so the shadow cannot hold it
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      shAddr  <= '0;
      shData  <= '0;
      shValid <= 1'b0;
    end else if (state == WR_HOLD) begin
      shAddr  <= RW;
      shData  <= BusW;
      shValid <= 1'b1;
    end
  end

  assign rdA = (shValid && (shAddr == RA)) ? shData : BusA;
  assign rdB = (shValid && (shAddr == RB)) ? shData : BusB;
`else
  assign rdA = BusA;
  assign rdB = BusB;
`endif

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Bench for rf_access_ctrl: table vectors, hand sequences for reset/back-to-back/bypass, random traffic.
// Register file modelled here, written on the falling edge while RegWr is high.
module tb_rf_access_ctrl;

  localparam int RDW = 2;
  localparam int DW  = 64;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          req_valid, req_ready, req_wr;
  logic [4:0]    req_a, req_b;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_a, rsp_b;
  logic [4:0]    RA, RB, RW;
  logic          RegWr;
  logic [DW-1:0] BusW, BusA, BusB;

  logic [DW-1:0] rf [32] = '{default: '0};
  logic [DW-1:0] mdl [32] = '{default: '0};
  logic          forceZero = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  rf_access_ctrl #(.READ_WAIT(RDW), .DW(DW)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_a(req_a), .req_b(req_b), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_err(rsp_err),
    .RA(RA), .RB(RB), .RW(RW), .RegWr(RegWr), .BusW(BusW),
    .BusA(BusA), .BusB(BusB)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (RegWr) rf[RW] <= BusW;
  assign BusA = forceZero ? '0 : rf[RA];
  assign BusB = forceZero ? '0 : rf[RB];

  initial begin
    #400000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    bit          wr;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [63:0] wd;
    int          hold;
    logic [63:0] eA;
    logic [63:0] eB;
    bit          eErr;
    int          eLat;
    int          eWr;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic xact(input string nm, input bit wr, input logic [4:0] a, input logic [4:0] b,
                      input logic [63:0] wd, input int hold, input logic [63:0] eA,
                      input logic [63:0] eB, input bit eErr, input int eLat, input int eWr);
    int n, lat, wrCnt;
    logic [4:0]  rwSeen;
    logic [63:0] busWSeen;
    bit ok;
    @(negedge Clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (!req_ready) begin
      chk({nm, " ready_timeout"}, 64'(req_ready), 64'd1);
      return;
    end
    req_valid = 1'b1; req_wr = wr; req_a = a; req_b = b; req_wdata = wd; rsp_ready = 1'b0;
    @(posedge Clk);
    #1 req_valid = 1'b0;
    lat = 0; wrCnt = 0; rwSeen = '0; busWSeen = '0;
    do begin
      @(negedge Clk);
      lat++;
      if (RegWr) begin
        wrCnt++;
        rwSeen = RW;
        busWSeen = BusW;
      end
    end while (!rsp_valid && lat < 50);
    chk({nm, " latency"}, 64'(lat), 64'(eLat));
    chk({nm, " regwr_pulses"}, 64'(wrCnt), 64'(eWr));
    if (eWr == 1) begin
      chk({nm, " RW"}, 64'(rwSeen), 64'(a));
      chk({nm, " BusW"}, busWSeen, wd);
    end
    chk({nm, " rsp_a"}, rsp_a, eA);
    chk({nm, " rsp_b"}, rsp_b, eB);
    chk({nm, " rsp_err"}, 64'(rsp_err), 64'(eErr));
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      ok = rsp_valid && !req_ready && (rsp_a === eA) && (rsp_b === eB) && (rsp_err === eErr);
      chk($sformatf("%s hold%0d", nm, i), 64'(ok), 64'd1);
    end
    rsp_ready = 1'b1;
    @(posedge Clk);
    #1 rsp_ready = 1'b0;
    @(negedge Clk);
    chk({nm, " back_idle"}, 64'({rsp_valid, req_ready}), 64'd1);
  endtask

  initial begin
    int acc[$];
    bit          wr;
    logic [4:0]  a, b;
    logic [63:0] wd, eA, eB;
    int          hold;

    tbl[0] = '{1'b0, 5'd0,  5'd31, 64'd0, 0, 64'd0, 64'd0, 1'b0, RDW + 1, 0};
    tbl[1] = '{1'b1, 5'd5,  5'd0,  64'hDEAD_BEEF_0000_0001, 0, 64'd0, 64'd0, 1'b0, 2, 1};
    tbl[2] = '{1'b0, 5'd5,  5'd31, 64'd0, 1, 64'hDEAD_BEEF_0000_0001, 64'd0, 1'b0, RDW + 1, 0};
    tbl[3] = '{1'b1, 5'd31, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 2, 64'd0, 64'd0, 1'b1, 1, 0};
    tbl[4] = '{1'b0, 5'd31, 5'd5,  64'd0, 10, 64'd0, 64'hDEAD_BEEF_0000_0001, 1'b0, RDW + 1, 0};
    tbl[5] = '{1'b1, 5'd12, 5'd3,  64'h0123_4567_89AB_CDEF, 0, 64'd0, 64'd0, 1'b0, 2, 1};
    tbl[6] = '{1'b0, 5'd12, 5'd12, 64'd0, 0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, RDW + 1, 0};
    tbl[7] = '{1'b1, 5'd5,  5'd9,  64'h55, 3, 64'd0, 64'd0, 1'b0, 2, 1};
    tbl[8] = '{1'b0, 5'd5,  5'd12, 64'd0, 0, 64'h55, 64'h0123_4567_89AB_CDEF, 1'b0, RDW + 1, 0};

    Rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_a = '0; req_b = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset ctl", 64'({RegWr, rsp_valid, rsp_err}), 64'd0);
    chk("reset rsp_data", rsp_a | rsp_b, 64'd0);
    chk("reset addr", 64'({RA, RB, RW}), 64'd0);
    chk("reset BusW", BusW, 64'd0);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("release req_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 9; i++) begin
      xact($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].a, tbl[i].b, tbl[i].wd, tbl[i].hold,
           tbl[i].eA, tbl[i].eB, tbl[i].eErr, tbl[i].eLat, tbl[i].eWr);
      if (tbl[i].wr && tbl[i].a != 5'd31) mdl[tbl[i].a] = tbl[i].wd;
    end

    // back-to-back reads with rsp_ready held high
    @(negedge Clk);
    req_valid = 1'b1; req_wr = 1'b0; req_a = 5'd3; req_b = 5'd4; rsp_ready = 1'b1;
    acc.delete();
    for (int i = 0; i < 12; i++) begin
      if (req_ready) acc.push_back(i);
      @(negedge Clk);
    end
    req_valid = 1'b0;
    chk("b2b_rd accepts", 64'(acc.size()), 64'd3);
    for (int i = 1; i < acc.size(); i++)
      chk($sformatf("b2b_rd spacing%0d", i), 64'(acc[i] - acc[i-1]), 64'(RDW + 2));
    repeat (3) @(negedge Clk);

    // back-to-back writes
    req_valid = 1'b1; req_wr = 1'b1; req_a = 5'd9; req_wdata = 64'h9999_0000_1111_2222;
    acc.delete();
    for (int i = 0; i < 12; i++) begin
      if (req_ready) acc.push_back(i);
      @(negedge Clk);
    end
    req_valid = 1'b0;
    mdl[9] = 64'h9999_0000_1111_2222;
    chk("b2b_wr accepts", 64'(acc.size()), 64'd4);
    for (int i = 1; i < acc.size(); i++)
      chk($sformatf("b2b_wr spacing%0d", i), 64'(acc[i] - acc[i-1]), 64'd3);
    repeat (3) @(negedge Clk);
    rsp_ready = 1'b0;
    xact("rd9", 1'b0, 5'd9, 5'd5, 64'd0, 0, mdl[9], mdl[5], 1'b0, RDW + 1, 0);

    // reset while the write strobe is high
    @(negedge Clk);
    chk("rstwr ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_wr = 1'b1; req_a = 5'd20; req_wdata = 64'hA5A5_5A5A_0F0F_F0F0;
    @(posedge Clk);
    #1 req_valid = 1'b0; Rst_n = 1'b0;
    @(negedge Clk);
    chk("rstwr strobe_before", 64'(RegWr), 64'd1);
    @(negedge Clk);
    chk("rstwr dropped", 64'({RegWr, rsp_valid, req_ready}), 64'd0);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("rstwr release", 64'({RegWr, rsp_valid, req_ready}), 64'd1);
    mdl[20] = 64'hA5A5_5A5A_0F0F_F0F0;
    xact("rd20", 1'b0, 5'd20, 5'd31, 64'd0, 0, mdl[20], 64'd0, 1'b0, RDW + 1, 0);

    // bypass: RF read path forced to zero
    xact("wr7", 1'b1, 5'd7, 5'd0, 64'h1234, 0, 64'd0, 64'd0, 1'b0, 2, 1);
    mdl[7] = 64'h1234;
    forceZero = 1'b1;
`ifdef RF_ACCESS_BYPASS_EN
    xact("byp7", 1'b0, 5'd7, 5'd0, 64'd0, 0, 64'h1234, 64'd0, 1'b0, RDW + 1, 0);
`else
    xact("byp7", 1'b0, 5'd7, 5'd0, 64'd0, 0, 64'd0, 64'd0, 1'b0, RDW + 1, 0);
`endif
    forceZero = 1'b0;

    // random traffic against the array model
    for (int i = 0; i < 40; i++) begin
      wr   = 1'($urandom_range(0, 1));
      a    = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      b    = 5'($urandom_range(0, 31));
      wd   = {$urandom, $urandom};
      hold = int'($urandom_range(0, 3));
      eA   = wr ? 64'd0 : mdl[a];
      eB   = wr ? 64'd0 : mdl[b];
      xact($sformatf("rnd%0d", i), wr, a, b, wd, hold, eA, eB, wr && (a == 5'd31),
           wr ? ((a == 5'd31) ? 1 : 2) : RDW + 1, (wr && a != 5'd31) ? 1 : 0);
      if (wr && a != 5'd31) mdl[a] = wd;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_access_ctrl.md
RF_ACCESS_CTRL -- requirements
Module: rf_access_ctrl

Interface
REQ-001 Parameter READ_WAIT, default 1, number of Clk cycles RA/RB are held stable before BusA/BusB are sampled (legal 1..7).
REQ-002 Parameter DW, default 64, data width of BusW/BusA/BusB and response data.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  request offered.
REQ-006 req_ready  output  1  request accepted when req_valid&&req_ready at rising Clk.
REQ-007 req_wr  input  1  1 = write, 0 = read pair.
REQ-008 req_a, req_b  input  5 each  read addresses (read); req_a is write address (write).
REQ-009 req_wdata  input  DW  write data.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumed when rsp_valid&&rsp_ready.
REQ-012 rsp_a, rsp_b  output  DW each  read data; zero for writes.
REQ-013 rsp_err  output  1  set on write to register 31.
REQ-014 RA, RB, RW  output  5 each  register-file addresses.
REQ-015 RegWr  output  1  register-file write enable.
REQ-016 BusW  output  DW  register-file write data.
REQ-017 BusA, BusB  input  DW each  register-file read data.

Function
REQ-018 FSM states: IDLE, RD_WAIT, WR_HOLD, RSP; req_ready SHALL be 1 only in IDLE.
REQ-019 IDLE, read accepted: RA<=req_a, RB<=req_b, counter<=READ_WAIT, go RD_WAIT.
REQ-020 RD_WAIT: decrement counter each cycle; at counter==1 capture BusA->rsp_a, BusB->rsp_b, go RSP; read latency accept-to-rsp_valid = READ_WAIT+1 cycles.
REQ-021 IDLE, write accepted with req_a!=31: RW<=req_a, BusW<=req_wdata, RegWr<=1, go WR_HOLD.
REQ-022 WR_HOLD: RegWr SHALL stay 1 for exactly one full Clk period (covers one falling edge), then RegWr<=0, go RSP with rsp_err=0.
REQ-023 Write to register 31: RegWr SHALL never assert; go directly to RSP with rsp_err=1.
REQ-024 RSP: rsp_valid=1, rsp_a/rsp_b/rsp_err stable until rsp_ready; on handshake return to IDLE next cycle.
REQ-025 RA, RB, RW, BusW SHALL hold their last value outside active operations (no glitching while RegWr=1).
REQ-026 Requests while not in IDLE are not accepted; req_valid with req_ready=0 has no effect.
REQ-027 Back-to-back: minimum accept-to-accept spacing = READ_WAIT+2 cycles (read) or 3 cycles (write) with rsp_ready held 1.

Reset
REQ-028 Rst_n=0 at rising Clk SHALL force IDLE, RegWr=0, rsp_valid=0, rsp_err=0, rsp_a=rsp_b=0, RA=RB=RW=0, BusW=0, counter=0.
REQ-029 Reset mid-write SHALL drop RegWr in the same cycle reset is sampled; the pending response is discarded.
REQ-030 req_ready SHALL be 0 while Rst_n=0 and 1 on the first cycle after release.

Configuration
REQ-031 Macro RF_ACCESS_BYPASS_EN defined: a shadow (addr, data, valid) of the last completed write is kept; a read whose req_a/req_b matches a valid shadow address SHALL return shadow data instead of BusA/BusB; shadow cleared on reset; shadow never written for register 31.
REQ-032 Macro RF_ACCESS_BYPASS_EN undefined: no shadow logic; read data always from BusA/BusB.

Verification
REQ-033 Reset, then read req_a=0,req_b=31 with RF zeroed -> rsp_valid after READ_WAIT+1 cycles, rsp_a=0, rsp_b=0, rsp_err=0.
REQ-034 Write req_a=5,req_wdata=64'hDEAD_BEEF_0000_0001 -> RegWr=1 for one period, RW=5; subsequent read req_a=5 -> rsp_a=64'hDEAD_BEEF_0000_0001.
REQ-035 Write req_a=31,req_wdata=64'hFFFF_FFFF_FFFF_FFFF -> RegWr never 1, rsp_err=1; read 31 -> 0.
REQ-036 Hold rsp_ready=0 for 10 cycles after read response -> rsp_valid, rsp_a/rsp_b stable, req_ready=0 throughout.
REQ-037 Assert Rst_n=0 during WR_HOLD -> RegWr=0 at next edge, rsp_valid=0, req_ready=1 after release; target register unchanged if no falling edge occurred with RegWr=1.
REQ-038 With RF_ACCESS_BYPASS_EN: write reg 7=64'h1234, force BusA=0, read 7 -> rsp_a=64'h1234; without macro -> rsp_a=0.
